uart_rx_ctrl: RTL and testbench
===============================

// Module: uart_rx_ctrl
// PURPOSE
//  Control/sequencing block for the UART receiver. Sits between the UART RX core and the system.
//  Owns the RX configuration (parity enable/type, prescale) and applies changes only between frames.
//  Buffers received bytes in a DEPTH-entry FIFO with a valid/ready output.
//  Keeps parity/stop error statistics and a sticky overflow flag.
// PARAMETERS
//  DEPTH        4   FIFO entries; power of 2, >=2
//  DATA_W       8   received data width
//  PRESCALE_RST 8   prescale value loaded at reset (6-bit field)
//  PAR_EN_RST   1   parity enable loaded at reset
//  PAR_TYP_RST  0   parity type loaded at reset (0 even, 1 odd)
// PORTS
//  CLK          in   1        single clock, all logic on posedge
//  RST          in   1        synchronous, active-high reset
//  cfg_req      in   1        1-cycle pulse: request new config from cfg_* inputs
//  cfg_par_en   in   1        requested parity enable, sampled with cfg_req
//  cfg_par_typ  in   1        requested parity type, sampled with cfg_req
//  cfg_prescale in   6        requested prescale, sampled with cfg_req
//  cfg_busy     out  1        high from the cycle after an accepted cfg_req until the cycle after cfg_ack
//  cfg_ack      out  1        1-cycle pulse: new config is now active
//  rx_busy      in   1        RX core is inside a frame (FSM not IDLE)
//  rx_en        out  1        RX core may start a new frame
//  par_en       out  1        active parity enable to RX core
//  par_typ      out  1        active parity type to RX core
//  prescale     out  6        active prescale to RX core
//  rx_data      in   DATA_W   received byte; valid with rx_valid
//  rx_valid     in   1        1-cycle pulse: rx_data is a good frame
//  par_err      in   1        1-cycle pulse: parity error detected
//  stp_err      in   1        1-cycle pulse: stop error detected
//  m_data       out  DATA_W   FIFO head
//  m_valid      out  1        FIFO not empty
//  m_ready      in   1        consumer accepts; pop when m_valid & m_ready
//  fifo_level   out  $clog2(DEPTH)+1   current occupancy, 0..DEPTH
//  overflow     out  1        sticky: a byte was dropped
//  par_err_cnt  out  8        saturating parity error count
//  stp_err_cnt  out  8        saturating stop error count
//  clr_stat     in   1        clear overflow and both counters
// BEHAVIOUR
//  Reset (RST=1 at posedge): state RUN; par_en=PAR_EN_RST, par_typ=PAR_TYP_RST, prescale=PRESCALE_RST.
//   FIFO empty, m_valid=0, m_data=0, fifo_level=0.
//   overflow=0, counters=0, cfg_ack=0, cfg_busy=0, rx_en=1.
//   Reset mid-frame or mid-config discards the pending config and all FIFO contents.
//  Config FSM (registered state and outputs):
//   RUN:   rx_en=1. On cfg_req, latch cfg_* into the pending regs and go to HOLD; cfg_busy=1 the next cycle.
//   HOLD:  rx_en=0. A frame already in progress completes. When rx_busy==0, go to APPLY.
//   APPLY: for one cycle copy pending to par_en/par_typ/prescale and assert cfg_ack; rx_en=0.
//          Next cycle: RUN, cfg_busy=0, rx_en=1.
//   cfg_req while in HOLD or APPLY is ignored (no queueing).
//   Minimum cfg_req-to-cfg_ack latency is 2 cycles, reached when rx_busy is already 0.
//  FIFO:
//   Push on rx_valid. Pop on m_valid & m_ready.
//   Pushed data is visible on m_data/m_valid the following cycle (1-cycle latency).
//   m_data/m_valid are stable while m_valid & !m_ready.
//   Full and push without pop: byte dropped, overflow set; occupancy unchanged.
//   Full with push and pop in the same cycle: both occur, no drop, level stays DEPTH.
//   Empty with push: pop is not possible in that cycle. Pointers wrap modulo DEPTH.
//  Statistics:
//   par_err/stp_err each increment their own counter by 1; counters saturate at 255.
//   clr_stat has priority over an increment or overflow in the same cycle: the result is 0.
//   rx_valid together with an error pulse is legal; both actions occur.
// TESTING
//  Reset, then 3 rx_valid bytes 0xA5,0x3C,0xFF with m_ready=0 -> fifo_level=3; m_ready=1 -> pops A5,3C,FF in order.
//  6 rx_valid bytes with m_ready=0, DEPTH=4 -> first 4 kept, overflow=1, fifo_level=4; clr_stat -> overflow=0.
//  FIFO full, rx_valid & m_ready in the same cycle -> level stays 4, new byte at tail, overflow stays 0.
//  rx_busy=1, cfg_req with prescale=16, par_en=0 -> rx_en=0, no ack; rx_busy falls -> cfg_ack 1 cycle later, prescale=16.
//  cfg_req with rx_busy=0 -> cfg_ack 2 cycles later; second cfg_req during HOLD -> ignored.
//  300 par_err pulses -> par_err_cnt=255; clr_stat together with a par_err pulse -> par_err_cnt=0.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// UART receiver control: frame-safe configuration handoff, receive FIFO with
// valid/ready output, and parity/stop error statistics.
module uart_rx_ctrl #(
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned DATA_W       = 8,
   parameter logic [5:0]  PRESCALE_RST = 6'd8,
   parameter logic        PAR_EN_RST   = 1'b1,
   parameter logic        PAR_TYP_RST  = 1'b0,
   localparam int unsigned PTR_W       = $clog2(DEPTH),
   localparam int unsigned LVL_W       = PTR_W + 1
) (
   input  logic              CLK,
   input  logic              RST,
   // configuration request
   input  logic              cfg_req,
   input  logic              cfg_par_en,
   input  logic              cfg_par_typ,
   input  logic [5:0]        cfg_prescale,
   output logic              cfg_busy,
   output logic              cfg_ack,
   // RX core control
   input  logic              rx_busy,
   output logic              rx_en,
   output logic              par_en,
   output logic              par_typ,
   output logic [5:0]        prescale,
   // RX core results
   input  logic [DATA_W-1:0] rx_data,
   input  logic              rx_valid,
   input  logic              par_err,
   input  logic              stp_err,
   // data output stream
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [LVL_W-1:0]  fifo_level,
   // statistics
   output logic              overflow,
   output logic [7:0]        par_err_cnt,
   output logic [7:0]        stp_err_cnt,
   input  logic              clr_stat
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_HOLD  = 2'd1,
      ST_APPLY = 2'd2
   } state_e;

   // ------------------------------------------------------------------
   // Configuration FSM
   // ------------------------------------------------------------------
   state_e     state_q, state_d;
   logic       cfg_busy_q, cfg_busy_d;
   logic       cfg_ack_q, cfg_ack_d;
   logic       rx_en_q, rx_en_d;
   logic       pend_par_en_q, pend_par_en_d;
   logic       pend_par_typ_q, pend_par_typ_d;
   logic [5:0] pend_prescale_q, pend_prescale_d;
   logic       par_en_q, par_en_d;
   logic       par_typ_q, par_typ_d;
   logic [5:0] prescale_q, prescale_d;

   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      state_d         = state_q;
      cfg_busy_d      = cfg_busy_q;
      cfg_ack_d       = 1'b0;
      rx_en_d         = rx_en_q;
      pend_par_en_d   = pend_par_en_q;
      pend_par_typ_d  = pend_par_typ_q;
      pend_prescale_d = pend_prescale_q;
      par_en_d        = par_en_q;
      par_typ_d       = par_typ_q;
      prescale_d      = prescale_q;
      case (state_q)
         ST_RUN: begin
            if (cfg_req) begin
               state_d         = ST_HOLD;
               pend_par_en_d   = cfg_par_en;
               pend_par_typ_d  = cfg_par_typ;
               pend_prescale_d = cfg_prescale;
               cfg_busy_d      = 1'b1;
               rx_en_d         = 1'b0;
            end
         end
         ST_HOLD: begin
            // Wait for the frame in flight to finish before switching settings.
            if (!rx_busy) begin
               state_d    = ST_APPLY;
               par_en_d   = pend_par_en_q;
               par_typ_d  = pend_par_typ_q;
               prescale_d = pend_prescale_q;
               cfg_ack_d  = 1'b1;
            end
         end
         ST_APPLY: begin
            state_d    = ST_RUN;
            cfg_busy_d = 1'b0;
            rx_en_d    = 1'b1;
         end
         default: begin
            state_d    = ST_RUN;
            cfg_busy_d = 1'b0;
            rx_en_d    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (RST) begin
         state_q         <= ST_RUN;
         cfg_busy_q      <= 1'b0;
         cfg_ack_q       <= 1'b0;
         rx_en_q         <= 1'b1;
         pend_par_en_q   <= PAR_EN_RST;
         pend_par_typ_q  <= PAR_TYP_RST;
         pend_prescale_q <= PRESCALE_RST;
         par_en_q        <= PAR_EN_RST;
         par_typ_q       <= PAR_TYP_RST;
         prescale_q      <= PRESCALE_RST;
      end else begin
         state_q         <= state_d;
         cfg_busy_q      <= cfg_busy_d;
         cfg_ack_q       <= cfg_ack_d;
         rx_en_q         <= rx_en_d;
         pend_par_en_q   <= pend_par_en_d;
         pend_par_typ_q  <= pend_par_typ_d;
         pend_prescale_q <= pend_prescale_d;
         par_en_q        <= par_en_d;
         par_typ_q       <= par_typ_d;
         prescale_q      <= prescale_d;
      end
   end

   assign cfg_busy = cfg_busy_q;
   assign cfg_ack  = cfg_ack_q;
   assign rx_en    = rx_en_q;
   assign par_en   = par_en_q;
   assign par_typ  = par_typ_q;
   assign prescale = prescale_q;

   // ------------------------------------------------------------------
   // Receive FIFO and statistics
   // ------------------------------------------------------------------
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]  count_q, count_d;
   logic              overflow_q, overflow_d;
   logic [7:0]        par_cnt_q, par_cnt_d;
   logic [7:0]        stp_cnt_q, stp_cnt_d;
   logic              full, pop, push, drop;

   always_comb begin
      full = (count_q == LVL_W'(DEPTH));
      pop  = m_valid & m_ready;
      // A full FIFO still accepts a byte when the head leaves in the same cycle.
      push = rx_valid & (!full | pop);
      drop = rx_valid & full & !pop;

      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d  = count_q + LVL_W'(push) - LVL_W'(pop);

      if (clr_stat) begin
         overflow_d = 1'b0;
         par_cnt_d  = 8'd0;
         stp_cnt_d  = 8'd0;
      end else begin
         overflow_d = overflow_q | drop;
         par_cnt_d  = (par_err && par_cnt_q != 8'hFF) ? par_cnt_q + 8'd1 : par_cnt_q;
         stp_cnt_d  = (stp_err && stp_cnt_q != 8'hFF) ? stp_cnt_q + 8'd1 : stp_cnt_q;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         par_cnt_q  <= 8'd0;
         stp_cnt_q  <= 8'd0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         par_cnt_q  <= par_cnt_d;
         stp_cnt_q  <= stp_cnt_d;
      end
   end

   // NOTE: storage is not reset; stale entries are never visible because m_data is masked when empty.
   always_ff @(posedge CLK) begin
      if (push) begin
         mem_q[wr_ptr_q] <= rx_data;
      end
   end

   assign m_valid     = (count_q != '0);
   assign m_data      = m_valid ? mem_q[rd_ptr_q] : '0;
   assign fifo_level  = count_q;
   assign overflow    = overflow_q;
   assign par_err_cnt = par_cnt_q;
   assign stp_err_cnt = stp_cnt_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: FIFO vector table plus hand-written
// configuration, statistics and reset sequences.
module tb_uart_rx_ctrl;

   logic       CLK;
   logic       RST;
   logic       cfg_req, cfg_par_en, cfg_par_typ;
   logic [5:0] cfg_prescale;
   logic       cfg_busy, cfg_ack;
   logic       rx_busy, rx_en, par_en, par_typ;
   logic [5:0] prescale;
   logic [7:0] rx_data;
   logic       rx_valid, par_err, stp_err;
   logic [7:0] m_data;
   logic       m_valid, m_ready;
   logic [2:0] fifo_level;
   logic       overflow;
   logic [7:0] par_err_cnt, stp_err_cnt;
   logic       clr_stat;

   int n_checks = 0;
   int n_fail   = 0;

   uart_rx_ctrl dut (
      .CLK          (CLK),
      .RST          (RST),
      .cfg_req      (cfg_req),
      .cfg_par_en   (cfg_par_en),
      .cfg_par_typ  (cfg_par_typ),
      .cfg_prescale (cfg_prescale),
      .cfg_busy     (cfg_busy),
      .cfg_ack      (cfg_ack),
      .rx_busy      (rx_busy),
      .rx_en        (rx_en),
      .par_en       (par_en),
      .par_typ      (par_typ),
      .prescale     (prescale),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .par_err      (par_err),
      .stp_err      (stp_err),
      .m_data       (m_data),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .fifo_level   (fifo_level),
      .overflow     (overflow),
      .par_err_cnt  (par_err_cnt),
      .stp_err_cnt  (stp_err_cnt),
      .clr_stat     (clr_stat)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic       rx_valid;
      logic [7:0] rx_data;
      logic       m_ready;
      logic       clr_stat;
      logic       exp_valid;
      logic [7:0] exp_data;
      logic [2:0] exp_level;
      logic       exp_ovf;
   } vec_t;

   vec_t vecs[$];

   function automatic void add_vec(logic v, logic [7:0] d, logic rdy, logic clr,
                                   logic ev, logic [7:0] ed, logic [2:0] el, logic eo);
      vec_t t;
      t.rx_valid  = v;
      t.rx_data   = d;
      t.m_ready   = rdy;
      t.clr_stat  = clr;
      t.exp_valid = ev;
      t.exp_data  = ed;
      t.exp_level = el;
      t.exp_ovf   = eo;
      vecs.push_back(t);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      cfg_req = 0; cfg_par_en = 0; cfg_par_typ = 0; cfg_prescale = 0;
      rx_busy = 0; rx_data = 0; rx_valid = 0; par_err = 0; stp_err = 0;
      m_ready = 0; clr_stat = 0;
   endtask

   initial begin
      // in order: rx_valid, data, m_ready, clr | m_valid, m_data, level, overflow
      add_vec(1, 8'hA5, 0, 0,  1, 8'hA5, 1, 0);
      add_vec(1, 8'h3C, 0, 0,  1, 8'hA5, 2, 0);
      add_vec(1, 8'hFF, 0, 0,  1, 8'hA5, 3, 0);
      add_vec(0, 8'h00, 1, 0,  1, 8'h3C, 2, 0);
      add_vec(0, 8'h00, 1, 0,  1, 8'hFF, 1, 0);
      add_vec(0, 8'h00, 1, 0,  0, 8'h00, 0, 0);
      add_vec(1, 8'h11, 0, 0,  1, 8'h11, 1, 0);
      add_vec(1, 8'h22, 0, 0,  1, 8'h11, 2, 0);
      add_vec(1, 8'h33, 0, 0,  1, 8'h11, 3, 0);
      add_vec(1, 8'h44, 0, 0,  1, 8'h11, 4, 0);
      add_vec(1, 8'h55, 0, 0,  1, 8'h11, 4, 1);
      add_vec(1, 8'h66, 0, 0,  1, 8'h11, 4, 1);
      add_vec(0, 8'h00, 0, 1,  1, 8'h11, 4, 0);
      add_vec(1, 8'h77, 1, 0,  1, 8'h22, 4, 0);
      add_vec(0, 8'h00, 1, 0,  1, 8'h33, 3, 0);
      add_vec(0, 8'h00, 1, 0,  1, 8'h44, 2, 0);
      add_vec(0, 8'h00, 1, 0,  1, 8'h77, 1, 0);
      add_vec(0, 8'h00, 1, 0,  0, 8'h00, 0, 0);
      add_vec(1, 8'h88, 1, 0,  1, 8'h88, 1, 0);
      add_vec(1, 8'h99, 1, 0,  1, 8'h99, 1, 0);
      add_vec(0, 8'h00, 1, 0,  0, 8'h00, 0, 0);
      add_vec(1, 8'hA0, 0, 0,  1, 8'hA0, 1, 0);
      add_vec(1, 8'hA1, 0, 0,  1, 8'hA0, 2, 0);
      add_vec(1, 8'hA2, 0, 0,  1, 8'hA0, 3, 0);
      add_vec(1, 8'hA3, 0, 0,  1, 8'hA0, 4, 0);
      add_vec(1, 8'hA4, 0, 1,  1, 8'hA0, 4, 0);
      add_vec(1, 8'hA5, 0, 0,  1, 8'hA0, 4, 1);
      add_vec(0, 8'h00, 1, 0,  1, 8'hA1, 3, 1);

      idle_inputs();
      RST = 1;
      tick();
      tick();
      check("rst_m_valid",  m_valid, 0);
      check("rst_m_data",   m_data, 0);
      check("rst_level",    fifo_level, 0);
      check("rst_overflow", overflow, 0);
      check("rst_par_cnt",  par_err_cnt, 0);
      check("rst_stp_cnt",  stp_err_cnt, 0);
      check("rst_cfg_ack",  cfg_ack, 0);
      check("rst_cfg_busy", cfg_busy, 0);
      check("rst_rx_en",    rx_en, 1);
      check("rst_par_en",   par_en, 1);
      check("rst_par_typ",  par_typ, 0);
      check("rst_prescale", prescale, 8);
      RST = 0;

      foreach (vecs[i]) begin
         rx_valid = vecs[i].rx_valid;
         rx_data  = vecs[i].rx_data;
         m_ready  = vecs[i].m_ready;
         clr_stat = vecs[i].clr_stat;
         tick();
         check($sformatf("vec%0d_m_valid", i),  m_valid,    vecs[i].exp_valid);
         check($sformatf("vec%0d_m_data", i),   m_data,     vecs[i].exp_data);
         check($sformatf("vec%0d_level", i),    fifo_level, vecs[i].exp_level);
         check($sformatf("vec%0d_overflow", i), overflow,   vecs[i].exp_ovf);
      end
      idle_inputs();

      // Config while a frame is in progress: held until rx_busy falls.
      rx_busy = 1;
      cfg_req = 1; cfg_prescale = 6'd16; cfg_par_en = 0; cfg_par_typ = 1;
      tick();
      cfg_req = 0; cfg_prescale = 0;
      check("hold_busy",     cfg_busy, 1);
      check("hold_rx_en",    rx_en, 0);
      check("hold_ack",      cfg_ack, 0);
      check("hold_prescale", prescale, 8);
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("hold%0d_ack", i),   cfg_ack, 0);
         check($sformatf("hold%0d_rx_en", i), rx_en, 0);
      end
      rx_busy = 0;
      tick();
      check("apply_ack",      cfg_ack, 1);
      check("apply_prescale", prescale, 16);
      check("apply_par_en",   par_en, 0);
      check("apply_par_typ",  par_typ, 1);
      check("apply_busy",     cfg_busy, 1);
      check("apply_rx_en",    rx_en, 0);
      tick();
      check("run_ack",   cfg_ack, 0);
      check("run_busy",  cfg_busy, 0);
      check("run_rx_en", rx_en, 1);

      // Idle RX: 2-cycle latency, second request during HOLD is dropped.
      cfg_req = 1; cfg_prescale = 6'd5; cfg_par_en = 1; cfg_par_typ = 0;
      tick();
      check("fast_hold_ack",  cfg_ack, 0);
      check("fast_hold_busy", cfg_busy, 1);
      cfg_prescale = 6'd33; cfg_par_typ = 1;
      tick();
      cfg_req = 0;
      check("fast_ack",      cfg_ack, 1);
      check("fast_prescale", prescale, 5);
      check("fast_par_en",   par_en, 1);
      check("fast_par_typ",  par_typ, 0);
      tick();
      check("fast_run_ack",  cfg_ack, 0);
      check("fast_run_busy", cfg_busy, 0);
      tick();
      check("ignored_ack",      cfg_ack, 0);
      check("ignored_busy",     cfg_busy, 0);
      check("ignored_prescale", prescale, 5);

      // Error statistics: saturation and clear priority.
      par_err = 1;
      for (int i = 0; i < 100; i++) tick();
      check("par_cnt_100", par_err_cnt, 100);
      for (int i = 0; i < 200; i++) tick();
      check("par_cnt_sat", par_err_cnt, 255);
      check("stp_cnt_idle", stp_err_cnt, 0);
      par_err = 0; stp_err = 1;
      for (int i = 0; i < 3; i++) tick();
      stp_err = 0;
      check("stp_cnt_3", stp_err_cnt, 3);
      check("par_cnt_hold", par_err_cnt, 255);
      clr_stat = 1; par_err = 1;
      tick();
      clr_stat = 0; par_err = 0;
      check("clr_par_cnt",  par_err_cnt, 0);
      check("clr_stp_cnt",  stp_err_cnt, 0);
      check("clr_overflow", overflow, 0);
      rx_valid = 1; rx_data = 8'h5A; par_err = 1;
      tick();
      rx_valid = 0; par_err = 0;
      check("err_push_cnt",   par_err_cnt, 1);
      check("err_push_level", fifo_level, 4);

      // Reset in the middle of a pending config discards it and the FIFO.
      rx_busy = 1;
      cfg_req = 1; cfg_prescale = 6'd40;
      tick();
      cfg_req = 0;
      check("pre_rst_busy", cfg_busy, 1);
      RST = 1;
      tick();
      RST = 0; rx_busy = 0;
      check("mid_rst_level",    fifo_level, 0);
      check("mid_rst_m_valid",  m_valid, 0);
      check("mid_rst_busy",     cfg_busy, 0);
      check("mid_rst_rx_en",    rx_en, 1);
      check("mid_rst_prescale", prescale, 8);
      check("mid_rst_par_cnt",  par_err_cnt, 0);
      tick();
      check("post_rst_ack",      cfg_ack, 0);
      check("post_rst_prescale", prescale, 8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
